// File: rtl/reduce_arbiter.sv
// Round-robin scheduler sharing one N-lane combinational adder tree among
// several vector streams; emits one tagged scalar sum per packet.
module reduce_arbiter #(
    parameter int N            = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int REQUESTERS   = 2,
    localparam int ID_WIDTH    = $clog2(REQUESTERS)
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [REQUESTERS-1:0]                         in_valid,
    input  logic [REQUESTERS-1:0]                         in_last,
    input  logic [REQUESTERS-1:0][N-1:0][DATA_WIDTH-1:0]  in_vector,
    output logic [REQUESTERS-1:0]                         in_ready,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [DATA_WIDTH-1:0]                         out_sum,
    output logic [ID_WIDTH-1:0]                           out_id,
    output logic [15:0]                                   out_beats
);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t                  state;
    logic [ID_WIDTH-1:0]     grant;
    logic [ID_WIDTH-1:0]     rr_ptr;
    logic [DATA_WIDTH-1:0]   acc;
    logic [15:0]             count;

    logic [DATA_WIDTH-1:0]   tree;
    logic [DATA_WIDTH-1:0]   acc_next;
    logic [15:0]             count_next;
    logic                    beat_ok;

    function automatic logic [DATA_WIDTH-1:0] tree_sum(
        input logic [N-1:0][DATA_WIDTH-1:0] lanes
    );
        logic [DATA_WIDTH-1:0] s;
        s = '0;
        for (int i = 0; i < N; i++) begin
            s = s + lanes[i];
        end
        return s;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] g);
        return (g == ID_WIDTH'(REQUESTERS - 1)) ? '0 : g + ID_WIDTH'(1);
    endfunction

    // First valid requester at or after ptr, wrapping around.
    function automatic logic [ID_WIDTH-1:0] rr_pick(
        input logic [REQUESTERS-1:0] v,
        input logic [ID_WIDTH-1:0]   ptr
    );
        logic [ID_WIDTH-1:0] sel;
        logic                found;
        int                  idx;
        sel   = ptr;
        found = 1'b0;
        for (int i = 0; i < REQUESTERS; i++) begin
            idx = (int'(ptr) + i) % REQUESTERS;
            if (!found && v[ID_WIDTH'(idx)]) begin
                sel   = ID_WIDTH'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    always_comb begin
        tree       = tree_sum(in_vector[grant]);
        acc_next   = acc + tree;
        count_next = sat_inc(count);
        beat_ok    = (state == BUSY) && in_valid[grant];
    end

    always_comb begin
        in_ready = '0;
        if (state == BUSY) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            acc       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_id    <= '0;
            out_beats <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|in_valid) begin
                        grant <= rr_pick(in_valid, rr_ptr);
                        acc   <= '0;
                        count <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // A dropped in_valid simply stalls with the grant held.
                    if (beat_ok) begin
                        acc   <= acc_next;
                        count <= count_next;
                        if (in_last[grant]) begin
                            out_sum   <= acc_next;
                            out_id    <= grant;
                            out_beats <= count_next;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        rr_ptr    <= wrap_inc(grant);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reduce_arbiter.sv
// Scoreboard bench for reduce_arbiter: per-requester beat queues feed the DUT,
// expected packet results are queued at stimulus time and popped on each handshake.
module tb_reduce_arbiter;

    localparam int N = 8;
    localparam int W = 32;
    localparam int R = 2;

    typedef logic [N-1:0][W-1:0] vec_t;
    typedef struct {
        vec_t v;
        logic last;
    } beat_t;
    typedef struct {
        logic [0:0]   id;
        logic [W-1:0] sum;
        logic [15:0]  beats;
    } res_t;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [R-1:0]           in_valid;
    logic [R-1:0]           in_last;
    logic [R-1:0][N-1:0][W-1:0] in_vector;
    logic [R-1:0]           in_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [W-1:0]           out_sum;
    logic [0:0]             out_id;
    logic [15:0]            out_beats;

    beat_t bq0[$];
    beat_t bq1[$];
    res_t  exp_q[$];
    logic [R-1:0] hold_off;
    int checks = 0;
    int passed = 0;

    reduce_arbiter #(.N(N), .DATA_WIDTH(W), .REQUESTERS(R)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_last(in_last), .in_vector(in_vector),
        .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_id(out_id), .out_beats(out_beats)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] lane_sum(input vec_t v);
        logic [W-1:0] s = '0;
        for (int i = 0; i < N; i++) s = s + v[i];
        return s;
    endfunction

    function automatic vec_t fill(input logic [W-1:0] x);
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = x;
        return v;
    endfunction

    task automatic push_beat(input int r, input vec_t v, input logic last);
        beat_t b;
        b.v = v;
        b.last = last;
        if (r == 0) bq0.push_back(b);
        else bq1.push_back(b);
    endtask

    task automatic push_exp(input logic [0:0] id, input logic [W-1:0] sum, input logic [15:0] beats);
        res_t e;
        e.id = id;
        e.sum = sum;
        e.beats = beats;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && bq0.size() == 0 && bq1.size() == 0) break;
        end
        repeat (2) @(negedge clk);
    endtask

    // Beat driver and result monitor
    initial begin
        logic [R-1:0] hs;
        res_t e;
        in_valid = '0;
        in_last = '0;
        in_vector = '0;
        forever begin
            @(negedge clk);
            hs = in_valid & in_ready;
            if (!reset && out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL scoreboard_unexpected: got id=%0d sum=%h beats=%0d, required no result",
                             out_id, out_sum, out_beats);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_id, out_sum, out_beats} !== {e.id, e.sum, e.beats})
                        $display("FAIL scoreboard_result: got id=%0d sum=%h beats=%0d, required id=%0d sum=%h beats=%0d",
                                 out_id, out_sum, out_beats, e.id, e.sum, e.beats);
                    else passed++;
                end
            end
            @(posedge clk);
            #1;
            if (hs[0] && bq0.size() > 0) void'(bq0.pop_front());
            if (hs[1] && bq1.size() > 0) void'(bq1.pop_front());
            if (bq0.size() > 0 && !hold_off[0]) begin
                in_valid[0] = 1'b1; in_vector[0] = bq0[0].v; in_last[0] = bq0[0].last;
            end else begin
                in_valid[0] = 1'b0; in_vector[0] = '0; in_last[0] = 1'b0;
            end
            if (bq1.size() > 0 && !hold_off[1]) begin
                in_valid[1] = 1'b1; in_vector[1] = bq1[0].v; in_last[1] = bq1[0].last;
            end else begin
                in_valid[1] = 1'b0; in_vector[1] = '0; in_last[1] = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, required 0", out_valid);
        else passed++;
        checks++;
        if (out_sum !== '0) $display("FAIL reset_out_sum: got %h, required 0", out_sum);
        else passed++;
        checks++;
        if (out_id !== '0) $display("FAIL reset_out_id: got %0d, required 0", out_id);
        else passed++;
        checks++;
        if (out_beats !== '0) $display("FAIL reset_out_beats: got %0d, required 0", out_beats);
        else passed++;
        checks++;
        if (in_ready !== '0) $display("FAIL reset_in_ready: got %b, required 00", in_ready);
        else passed++;
    endtask

    task automatic test_round_robin;
        logic [0:0] got[4];
        int n = 0;
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            push_beat(0, fill(32'd1), 1'b1);
            push_beat(1, fill(32'd1), 1'b1);
        end
        for (int p = 0; p < 4; p++) push_exp(1'(p % 2), 32'd8, 16'd1);
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                got[n] = out_id;
                n++;
            end
        end
        checks++;
        if (n !== 4) $display("FAIL rr_count: got %0d results, required 4", n);
        else passed++;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got[i] !== 1'(i % 2)) $display("FAIL rr_order[%0d]: got id %0d, required %0d", i, got[i], i % 2);
            else passed++;
        end
        drain(40);
    endtask

    task automatic test_single;
        vec_t v;
        int hi = 0;
        logic [W-1:0] s = '0;
        logic [0:0] id = '0;
        logic [15:0] b = '0;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) v[i] = W'(i + 1);
        push_beat(0, v, 1'b0);
        push_beat(0, fill(32'd10), 1'b1);
        push_exp(1'b0, lane_sum(v) + lane_sum(fill(32'd10)), 16'd2);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) begin
                hi++;
                s = out_sum; id = out_id; b = out_beats;
            end
        end
        checks++;
        if (hi !== 1) $display("FAIL single_valid_cycles: got %0d, required 1", hi);
        else passed++;
        checks++;
        if (s !== 32'd116) $display("FAIL single_sum: got %0d, required 116", s);
        else passed++;
        checks++;
        if (id !== 1'b0) $display("FAIL single_id: got %0d, required 0", id);
        else passed++;
        checks++;
        if (b !== 16'd2) $display("FAIL single_beats: got %0d, required 2", b);
        else passed++;
        drain(20);
    endtask

    task automatic test_wrap;
        int k;
        @(posedge clk);
        #1;
        push_beat(1, fill(32'hFFFF_FFFF), 1'b1);
        push_exp(1'b1, lane_sum(fill(32'hFFFF_FFFF)), 16'd1);
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        checks++;
        if (!out_valid) $display("FAIL wrap_timeout: out_valid=%b, required 1 within 40 cycles", out_valid);
        else passed++;
        checks++;
        if (out_sum !== 32'hFFFF_FFF8) $display("FAIL wrap_sum: got %h, required fffffff8", out_sum);
        else passed++;
        checks++;
        if (out_beats !== 16'd1) $display("FAIL wrap_beats: got %0d, required 1", out_beats);
        else passed++;
        drain(20);
    endtask

    task automatic test_backpressure;
        vec_t v;
        int k;
        logic [W-1:0] s0;
        logic [0:0] id0;
        logic [15:0] b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) v[i] = W'(i * 3 + 5);
        push_beat(0, v, 1'b1);
        push_exp(1'b0, lane_sum(v), 16'd1);
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        checks++;
        if (!out_valid) $display("FAIL bp_timeout: out_valid=%b, required 1 within 40 cycles", out_valid);
        else passed++;
        s0 = out_sum; id0 = out_id; b0 = out_beats;
        push_beat(1, fill(32'd7), 1'b1);
        push_exp(1'b1, 32'd56, 16'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, out_sum, out_id, out_beats, in_ready} !== {1'b1, s0, id0, b0, 2'b00})
                $display("FAIL bp_hold[%0d]: got v=%b sum=%h id=%0d beats=%0d rdy=%b, required v=1 sum=%h id=%0d beats=%0d rdy=00",
                         c, out_valid, out_sum, out_id, out_beats, in_ready, s0, id0, b0);
            else passed++;
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain(40);
    endtask

    task automatic test_stall_gap;
        vec_t v;
        logic [W-1:0] sum = '0;
        logic [29:0] pat = 30'h6C;
        int acc_n = 0;
        int gap_chk = 0;
        bit pushed1 = 1'b0;
        @(posedge clk);
        #1;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < N; i++) v[i] = $urandom;
            push_beat(0, v, b == 2);
            sum = sum + lane_sum(v);
        end
        push_exp(1'b0, sum, 16'd3);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (!in_valid[0] && acc_n >= 1 && acc_n <= 2) begin
                gap_chk++;
                checks++;
                if (in_ready !== 2'b01) $display("FAIL gap_grant_held[%0d]: got in_ready=%b, required 01", c, in_ready);
                else passed++;
            end
            if (in_valid[0] && in_ready[0]) acc_n++;
            if (acc_n >= 1 && !pushed1) begin
                push_beat(1, fill(32'd3), 1'b0);
                push_beat(1, fill(32'd4), 1'b1);
                push_exp(1'b1, 32'd56, 16'd2);
                pushed1 = 1'b1;
            end
            hold_off[0] = pat[c];
        end
        hold_off = '0;
        checks++;
        if (gap_chk == 0) $display("FAIL gap_exercised: got %0d gap cycles, required >0", gap_chk);
        else passed++;
        drain(60);
    endtask

    task automatic test_reset_mid;
        int k;
        @(posedge clk);
        #1;
        push_beat(0, fill(32'd2), 1'b1);
        push_exp(1'b0, 32'd16, 16'd1);
        drain(40);
        push_beat(1, fill(32'd9), 1'b0);
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bq1.size() == 0) break;
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_sum, out_id, out_beats, in_ready} !== '0)
            $display("FAIL midreset_outputs: got v=%b sum=%h id=%0d beats=%0d rdy=%b, required all zero",
                     out_valid, out_sum, out_id, out_beats, in_ready);
        else passed++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) $display("FAIL midreset_no_result[%0d]: got out_valid=%b, required 0", c, out_valid);
            else passed++;
        end
        @(posedge clk);
        #1;
        push_beat(0, fill(32'd5), 1'b1);
        push_beat(1, fill(32'd6), 1'b1);
        push_exp(1'b0, 32'd40, 16'd1);
        push_exp(1'b1, 32'd48, 16'd1);
        drain(60);
    endtask

    initial begin
        out_ready = 1'b1;
        hold_off = '0;
        test_reset();
        test_round_robin();
        test_single();
        test_wrap();
        test_backpressure();
        test_stall_gap();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) $display("FAIL pending_results: got %0d outstanding, required 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
